controle_memoria_dados: RTL

CONTROLE_MEMORIA_DADOS -- requirements
Module: controle_memoria_dados

---
 rtl/controle_memoria_dados.sv | 110 +++++++++++
 1 files changed

// File: rtl/controle_memoria_dados.sv
// Data-memory controller: serialises processor loads/stores and a
// whole-memory zero-fill onto a single-port synchronous memory.
module controle_memoria_dados #(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 4
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              req,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              clear,
  output logic              busy,
  output logic              ack,
  output logic [DATA_W-1:0] rdata,
  output logic [ADDR_W-1:0] mem_endereco,
  output logic              mem_write,
  output logic              mem_read,
  output logic [DATA_W-1:0] mem_dado_in,
  input  logic [DATA_W-1:0] mem_dado_out
);

  typedef enum logic [1:0] {
    IDLE,
    WR,
    RD,
    CLR
  } state_t;

  localparam logic [ADDR_W-1:0] LAST = '1;

  state_t            state;
  state_t            next;
  logic [ADDR_W-1:0] cnt;
  logic [ADDR_W-1:0] a_addr;
  logic [DATA_W-1:0] a_wdata;
  logic              done;

  // last cycle of any operation; ack follows it by one edge
  assign done = (state == WR) || (state == RD) ||
                ((state == CLR) && (cnt == LAST));

  assign busy = (state != IDLE);

  // state, request latch, sweep counter, read capture and ack pulse
  always_ff @(posedge clock) begin
    if (reset) begin
      state   <= IDLE;
      cnt     <= '0;
      a_addr  <= '0;
      a_wdata <= '0;
      rdata   <= '0;
      ack     <= 1'b0;
    end else begin
      state <= next;
      ack   <= done;
      unique case (state)
        IDLE: begin
          if (clear) begin
            cnt <= '0;
          end else if (req) begin
            a_addr  <= addr;
            a_wdata <= wdata;
          end
        end
        RD:      rdata <= mem_dado_out;
        CLR:     cnt   <= cnt + 1'b1;
        default: ;
      endcase
    end
  end

  // next-state and memory-side strobes; reset masks the strobes
  always_comb begin
    next         = state;
    mem_write    = 1'b0;
    mem_read     = 1'b0;
    mem_endereco = '0;
    mem_dado_in  = '0;
    unique case (state)
      IDLE: begin
        if (clear)    next = CLR;
        else if (req) next = we ? WR : RD;
      end
      WR: begin
        mem_write    = 1'b1;
        mem_endereco = a_addr;
        mem_dado_in  = a_wdata;
        next         = IDLE;
      end
      RD: begin
        mem_read     = 1'b1;
        mem_endereco = a_addr;
        next         = IDLE;
      end
      CLR: begin
        mem_write    = 1'b1;
        mem_endereco = cnt;
        if (cnt == LAST) next = IDLE;
      end
      default: next = IDLE;
    endcase
    if (reset) begin
      mem_write = 1'b0;
      mem_read  = 1'b0;
    end
  end

endmodule
